regs_dump: RTL and testbench

- Debug readout engine for the 16-entry register file.
- On a start pulse it takes over the register file's first read-address port and walks x0..x15.
- Each 32-bit register is streamed out as four bytes over a byte-wide valid/ready interface, for the debug UART/radio link.
- Sits between the core's register file read port 1 (via an external address mux) and the debug transport.

---
 rtl/regs_dump_if.sv | 25 ++
 rtl/regs_dump.sv | 197 +++++++++++++++++++
 tb/tb_regs_dump.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regs_dump_if.sv
// Bundle between the dump engine, the register file read port and the debug byte stream.
// master: dump engine side; slave: core/transport side.
interface regs_dump_if #(
    parameter int ADRW = 4
);
    logic            start;
    logic            busy;
    logic            done;
    logic            dbg_active;
    logic [ADRW-1:0] dbg_adr;
    logic [31:0]     rf_data;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;

    modport master (
        input  start, rf_data, tx_ready,
        output busy, done, dbg_active, dbg_adr, tx_data, tx_valid
    );

    modport slave (
        output start, rf_data, tx_ready,
        input  busy, done, dbg_active, dbg_adr, tx_data, tx_valid
    );
endinterface

// File: rtl/regs_dump.sv
// Register file debug dump: walks x0..x(NREGS-1) via rs1 and streams each entry as four
// little-endian bytes. Define REGS_DUMP_CRC_EN to append a CRC-8 (poly 0x07) trailer byte.
module regs_dump #(
    parameter int NREGS = 16,
    parameter int ADRW  = 4
) (
    input  logic        clk,
    input  logic        reset,
    regs_dump_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_CAPT = 3'd2,
        S_SEND = 3'd3,
        S_FIN  = 3'd4
`ifdef REGS_DUMP_CRC_EN
        , S_CRC = 3'd5
`endif
    } state_t;

    localparam logic [ADRW-1:0] LAST_IDX = ADRW'(NREGS - 1);
    localparam logic [ADRW-1:0] IDX_ONE  = ADRW'(1);
    localparam logic [ADRW-1:0] IDX_ZERO = {ADRW{1'b0}};
`ifdef REGS_DUMP_CRC_EN
    localparam state_t S_AFTER_LAST = S_CRC;
`else
    localparam state_t S_AFTER_LAST = S_FIN;
`endif

    state_t          state_r, state_nxt_s;
    logic [ADRW-1:0] idx_r, idx_nxt_s;
    logic [1:0]      cnt_r, cnt_nxt_s;
    logic [31:0]     shift_r, shift_nxt_s;
    logic            hs_s, last_byte_s, last_reg_s;
    logic            busy_r, busy_nxt_s;
    logic            done_r, done_nxt_s;
    logic            tx_valid_r, tx_valid_nxt_s;
    logic [7:0]      tx_data_r, tx_data_nxt_s;
    logic [ADRW-1:0] dbg_adr_r, dbg_adr_nxt_s;
`ifdef REGS_DUMP_CRC_EN
    logic [7:0]      crc_r, crc_nxt_s;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
            else      c = {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    assign hs_s        = tx_valid_r & bus.tx_ready;
    assign last_byte_s = (cnt_r == 2'd3);
    assign last_reg_s  = (idx_r == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= S_IDLE;
        else        state_r <= state_nxt_s;
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.start) state_nxt_s = S_ADDR;
                else           state_nxt_s = S_IDLE;
            end
            S_ADDR: state_nxt_s = S_CAPT;
            S_CAPT: state_nxt_s = S_SEND;
            S_SEND: begin
                if (hs_s && last_byte_s) state_nxt_s = last_reg_s ? S_AFTER_LAST : S_ADDR;
                else                     state_nxt_s = S_SEND;
            end
`ifdef REGS_DUMP_CRC_EN
            S_CRC: begin
                if (hs_s) state_nxt_s = S_FIN;
                else      state_nxt_s = S_CRC;
            end
`endif
            S_FIN:   state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Datapath next values: register index, byte counter, shift register, CRC
    always_comb begin
        idx_nxt_s   = idx_r;
        cnt_nxt_s   = cnt_r;
        shift_nxt_s = shift_r;
`ifdef REGS_DUMP_CRC_EN
        crc_nxt_s   = crc_r;
`endif
        case (state_r)
            S_IDLE: begin
                idx_nxt_s = IDX_ZERO;
`ifdef REGS_DUMP_CRC_EN
                if (bus.start) crc_nxt_s = 8'h00;
                else           crc_nxt_s = crc_r;
`endif
            end
            S_CAPT: begin
                shift_nxt_s = bus.rf_data;
                cnt_nxt_s   = 2'd0;
            end
            S_SEND: begin
                if (hs_s) begin
                    shift_nxt_s = {8'h00, shift_r[31:8]};
                    cnt_nxt_s   = cnt_r + 2'd1;
`ifdef REGS_DUMP_CRC_EN
                    crc_nxt_s   = crc8_byte(crc_r, shift_r[7:0]);
`endif
                    if (last_byte_s && !last_reg_s) idx_nxt_s = idx_r + IDX_ONE;
                    else                            idx_nxt_s = idx_r;
                end else begin
                    shift_nxt_s = shift_r;
                end
            end
            S_FIN:   idx_nxt_s = IDX_ZERO;
            default: idx_nxt_s = idx_r;
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop
    always_comb begin
        busy_nxt_s     = 1'b0;
        done_nxt_s     = 1'b0;
        tx_valid_nxt_s = 1'b0;
        tx_data_nxt_s  = 8'h00;
        case (state_nxt_s)
            S_ADDR, S_CAPT: busy_nxt_s = 1'b1;
            S_SEND: begin
                busy_nxt_s     = 1'b1;
                tx_valid_nxt_s = 1'b1;
                tx_data_nxt_s  = shift_nxt_s[7:0];
            end
`ifdef REGS_DUMP_CRC_EN
            S_CRC: begin
                busy_nxt_s     = 1'b1;
                tx_valid_nxt_s = 1'b1;
                tx_data_nxt_s  = crc_nxt_s;
            end
`endif
            S_FIN:   done_nxt_s = 1'b1;
            default: busy_nxt_s = 1'b0;
        endcase
        if (busy_nxt_s) dbg_adr_nxt_s = idx_nxt_s;
        else            dbg_adr_nxt_s = IDX_ZERO;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r   <= IDX_ZERO;
            cnt_r   <= 2'd0;
            shift_r <= 32'h0000_0000;
`ifdef REGS_DUMP_CRC_EN
            crc_r   <= 8'h00;
`endif
        end else begin
            idx_r   <= idx_nxt_s;
            cnt_r   <= cnt_nxt_s;
            shift_r <= shift_nxt_s;
`ifdef REGS_DUMP_CRC_EN
            crc_r   <= crc_nxt_s;
`endif
        end
    end

    // Output registers; async reset drops tx_valid mid-dump without a clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            dbg_adr_r  <= IDX_ZERO;
        end else begin
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            tx_valid_r <= tx_valid_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            dbg_adr_r  <= dbg_adr_nxt_s;
        end
    end

    assign bus.busy       = busy_r;
    assign bus.dbg_active = busy_r;
    assign bus.done       = done_r;
    assign bus.tx_valid   = tx_valid_r;
    assign bus.tx_data    = tx_data_r;
    assign bus.dbg_adr    = dbg_adr_r;
endmodule

// File: tb/tb_regs_dump.sv
// Bench for regs_dump: expected byte stream built from a register-file image, checked each cycle.
// Honours REGS_DUMP_CRC_EN (adds the CRC trailer byte and one cycle).
module tb_regs_dump;
    localparam int NREGS = 16;
    localparam int ADRW  = 4;
`ifdef REGS_DUMP_CRC_EN
    localparam int NBYTES   = 65;
    localparam int DONE_CYC = 98;
`else
    localparam int NBYTES   = 64;
    localparam int DONE_CYC = 97;
`endif

    logic clk = 1'b0;
    logic reset;
    regs_dump_if #(.ADRW(ADRW)) bus();

    regs_dump #(.NREGS(NREGS), .ADRW(ADRW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] rfm [NREGS];
    always @(posedge clk) bus.rf_data <= rfm[bus.dbg_adr];

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit in_dump = 1'b0;
    int pos = 0, rel = 0, done_rel = -1, done_cnt = 0, stall_seen = 0;
    int stall_byte = -1, stall_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

`ifdef REGS_DUMP_CRC_EN
    function automatic logic [7:0] crc_of(input logic [7:0] q[$], input int n);
        logic [7:0] c = 8'h00;
        logic fb;
        for (int k = 0; k < n; k++)
            for (int i = 7; i >= 0; i--) begin
                fb = c[7] ^ q[k][i];
                c  = c << 1;
                if (fb) c = c ^ 8'h07;
            end
        return c;
    endfunction
`endif

    task automatic build_model();
        exp_q.delete();
        for (int r = 0; r < NREGS; r++)
            for (int b = 0; b < 4; b++) exp_q.push_back(rfm[r][8*b +: 8]);
`ifdef REGS_DUMP_CRC_EN
        exp_q.push_back(crc_of(exp_q, 64));
`endif
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        bit exp_busy, exp_done;
        int r;
        if (reset === 1'b1) begin
            if (in_dump) rel++;
            exp_busy = in_dump && (pos < NBYTES);
            exp_done = in_dump && (pos == NBYTES);
            r = pos / 4;
            if (r > NREGS - 1) r = NREGS - 1;
            check("busy", bus.busy, exp_busy);
            check("dbg_active", bus.dbg_active, exp_busy);
            check("dbg_adr", bus.dbg_adr, exp_busy ? 32'(r) : 32'd0);
            check("done", bus.done, exp_done);
            if (bus.done) done_cnt++;
            if (exp_done) begin
                done_rel = rel;
                in_dump  = 1'b0;
            end
            if (!exp_busy) begin
                check("tx_valid_idle", bus.tx_valid, 1'b0);
                check("tx_data_idle", bus.tx_data, 8'h00);
            end else if (bus.tx_valid) begin
                check("tx_data", bus.tx_data, exp_q[pos]);
                if (bus.tx_ready) begin
                    got_q.push_back(bus.tx_data);
                    pos++;
                end else begin
                    stall_seen++;
                end
            end
        end
    end

    // Sink ready, with an optional stall on one byte
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (in_dump && pos == stall_byte && stall_left > 0) begin
                bus.tx_ready = 1'b0;
                stall_left--;
            end else begin
                bus.tx_ready = 1'b1;
            end
        end
    end

    task automatic start_dump();
        pos = 0; rel = 0; done_rel = -1; done_cnt = 0; stall_seen = 0;
        got_q.delete();
        @(posedge clk);
        #2 bus.start = 1'b1;
        @(posedge clk);
        #1 in_dump = 1'b1;
        #1 bus.start = 1'b0;
    endtask

    task automatic finish_dump(input int extra, input string tag);
        for (int k = 0; k < 400 && in_dump; k++) @(negedge clk);
        #1;
        check({tag, "_timeout"}, in_dump, 1'b0);
        check({tag, "_done_cycle"}, done_rel, DONE_CYC + extra);
        check({tag, "_bytes"}, pos, NBYTES);
        repeat (8) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    task automatic wait_pos(input int p, input string tag);
        for (int k = 0; k < 300 && pos < p; k++) @(negedge clk);
        check({tag, "_reached"}, pos >= p, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < NREGS; i++) rfm[i] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2 bus.start = ~bus.start;
            @(negedge clk);
            check("rst_busy", bus.busy, 1'b0);
            check("rst_done", bus.done, 1'b0);
            check("rst_tx_valid", bus.tx_valid, 1'b0);
            check("rst_dbg_active", bus.dbg_active, 1'b0);
            check("rst_dbg_adr", bus.dbg_adr, 4'h0);
        end
        @(posedge clk);
        #2 bus.start = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        rfm[1]  = 32'h1122_3344;
        rfm[15] = 32'hDEAD_BEEF;
        build_model();
        check("model_b4", exp_q[4], 8'h44);
        check("model_b63", exp_q[63], 8'hDE);

        start_dump();
        finish_dump(0, "full");
        check("full_b4", got_q[4], 8'h44);
        check("full_b5", got_q[5], 8'h33);
        check("full_b6", got_q[6], 8'h22);
        check("full_b7", got_q[7], 8'h11);
        check("full_b60", got_q[60], 8'hEF);
        check("full_b61", got_q[61], 8'hBE);
        check("full_b62", got_q[62], 8'hAD);
        check("full_b63", got_q[63], 8'hDE);
        check("full_b0", got_q[0], 8'h00);

        stall_byte = 5;
        stall_left = 5;
        start_dump();
        finish_dump(5, "stall");
        check("stall_cycles", stall_seen, 5);
        check("stall_b5", got_q[5], 8'h33);
        stall_byte = -1;

        start_dump();
        wait_pos(20, "restart");
        @(posedge clk);
        #2 bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        finish_dump(0, "restart");

        start_dump();
        wait_pos(30, "abort");
        @(posedge clk);
        #2 reset = 1'b0;
        in_dump = 1'b0;
        #1;
        check("abort_tx_valid", bus.tx_valid, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        start_dump();
        finish_dump(0, "after_abort");
        check("after_abort_b0", got_q[0], 8'h00);
        check("after_abort_b4", got_q[4], 8'h44);

        for (int i = 0; i < NREGS; i++) rfm[i] = 32'hA0B0_C0D0 ^ (32'(i) * 32'h0101_0101);
        build_model();
        check("model_pat_b8", exp_q[8], 8'hD2);
        start_dump();
        finish_dump(0, "pattern");
        check("pattern_b9", got_q[9], 8'hC2);

`ifdef REGS_DUMP_CRC_EN
        for (int i = 0; i < NREGS; i++) rfm[i] = 32'h0;
        build_model();
        start_dump();
        finish_dump(0, "crc_zero");
        check("crc_zero_b64", got_q[64], 8'h00);

        rfm[1] = 32'h0000_0001;
        build_model();
        start_dump();
        finish_dump(0, "crc_one");
        check("crc_one_b64", got_q[64], crc_of(got_q, 64));
        check("crc_one_nonzero", got_q[64] != 8'h00, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
